deadlock_report_ctrl: RTL

DEADLOCK_REPORT_CTRL -- requirements
Module: deadlock_report_ctrl

---
 rtl/deadlock_pkg.sv | 14 +
 rtl/deadlock_report_ctrl_if.sv | 13 +
 rtl/deadlock_stall_counter.sv | 33 +++
 rtl/deadlock_report_ctrl.sv | 117 +++++++++++
 4 files changed

// File: rtl/deadlock_pkg.sv
// Shared types and default constants for the deadlock report controller.
package deadlock_pkg;

  localparam int unsigned DEF_CONFIRM_CYCLES = 1000;
  localparam int unsigned DEF_COUNT_W        = 16;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SUSPECT = 2'd1,
    ST_REPORT  = 2'd2,
    ST_DONE    = 2'd3
  } state_e;

endpackage

// File: rtl/deadlock_report_ctrl_if.sv
// Report handshake between the deadlock controller (master) and its consumer (slave).
interface deadlock_report_ctrl_if #(
  parameter int unsigned NUM_CH = 1
) ();

  logic              report_valid;
  logic              report_ready;
  logic [NUM_CH-1:0] report_info;

  modport master (output report_valid, output report_info, input  report_ready);
  modport slave  (input  report_valid, input  report_info, output report_ready);

endinterface

// File: rtl/deadlock_stall_counter.sv
// Consecutive-blocked-cycle counter: synchronous clear, reload to 1, saturating increment.
module deadlock_stall_counter #(
  parameter int unsigned COUNT_W   = 16,
  parameter int unsigned MAX_COUNT = 1000
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               clr,
  input  logic               load,
  input  logic               inc,
  output logic [COUNT_W-1:0] count,
  output logic               last_c
);

  localparam logic [COUNT_W-1:0] MAX_VAL  = COUNT_W'(MAX_COUNT);
  localparam logic [COUNT_W-1:0] LAST_VAL = COUNT_W'(MAX_COUNT - 1);

  // The next increment reaches the confirmation threshold.
  assign last_c = (count == LAST_VAL);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= COUNT_W'(1);
    end else if (inc && (count != MAX_VAL)) begin
      count <= count + COUNT_W'(1);
    end
  end

endmodule

// File: rtl/deadlock_report_ctrl.sv
// Confirms a persistent blocked-channel pattern and offers it once as a valid/ready report.
module deadlock_report_ctrl
  import deadlock_pkg::*;
#(
  parameter int unsigned NUM_CH         = 1,
  parameter int unsigned CONFIRM_CYCLES = DEF_CONFIRM_CYCLES,
  parameter int unsigned COUNT_W        = DEF_COUNT_W
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  block,
  input  logic [NUM_CH-1:0]     axis_block_info,
  input  logic                  clear,
  output logic                  suspect,
  output logic [COUNT_W-1:0]    stall_count,
  output logic                  deadlock_detected,
  deadlock_report_ctrl_if.master rpt
);

  state_e            state;
  logic [NUM_CH-1:0] cand;
  logic [NUM_CH-1:0] info_q;
  logic              valid_q;
  logic              cnt_clr_c;
  logic              cnt_load_c;
  logic              cnt_inc_c;
  logic              cnt_last_c;

  assign rpt.report_valid = valid_q;
  assign rpt.report_info  = info_q;

  deadlock_stall_counter #(
    .COUNT_W   (COUNT_W),
    .MAX_COUNT (CONFIRM_CYCLES)
  ) u_stall_counter (
    .clock  (clock),
    .reset  (reset),
    .clr    (cnt_clr_c),
    .load   (cnt_load_c),
    .inc    (cnt_inc_c),
    .count  (stall_count),
    .last_c (cnt_last_c)
  );

  // Counter control; the count is frozen once the report has been confirmed.
  always_comb begin
    cnt_clr_c  = 1'b0;
    cnt_load_c = 1'b0;
    cnt_inc_c  = 1'b0;
    if (clear) begin
      cnt_clr_c = 1'b1;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (block) cnt_load_c = 1'b1;
          else       cnt_clr_c  = 1'b1;
        end
        ST_SUSPECT: begin
          if (!block)                            cnt_clr_c  = 1'b1;
          else if (axis_block_info != cand)      cnt_load_c = 1'b1;
          else                                   cnt_inc_c  = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state             <= ST_IDLE;
      cand              <= '0;
      info_q            <= '0;
      valid_q           <= 1'b0;
      deadlock_detected <= 1'b0;
      suspect           <= 1'b0;
    end else if (clear) begin
      state             <= ST_IDLE;
      cand              <= '0;
      info_q            <= '0;
      valid_q           <= 1'b0;
      deadlock_detected <= 1'b0;
      suspect           <= 1'b0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (block) begin
            state   <= ST_SUSPECT;
            suspect <= 1'b1;
            cand    <= axis_block_info;
          end
        end
        ST_SUSPECT: begin
          if (!block) begin
            state   <= ST_IDLE;
            suspect <= 1'b0;
          end else if (axis_block_info != cand) begin
            cand <= axis_block_info;
          end else if (cnt_last_c) begin
            state             <= ST_REPORT;
            suspect           <= 1'b0;
            info_q            <= cand;
            valid_q           <= 1'b1;
            deadlock_detected <= 1'b1;
          end
        end
        ST_REPORT: begin
          if (valid_q && rpt.report_ready) begin
            state   <= ST_DONE;
            valid_q <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
